// File: rtl/whack_button_conditioner.sv
// Purpose : conditions raw player buttons (sync, debounce, press pulse) and hands presses to the game core.
// Latency : raw edge -> btn_level/btn_press after 2+DEBOUNCE_CYCLES edges; btn_press -> hit_valid/hit_idx one edge later.
// Backpres: single-entry hit slot; presses arriving while the slot is held (or losing arbitration) are dropped and flagged on overrun.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   btn_raw    asynchronous raw button levels, 1 = pressed
//   btn_level  debounced button levels
//   btn_press  one-cycle pulse per debounced rising edge
//   hit_valid  hit pending for the game core
//   hit_idx    index of the pending hit button
//   hit_ready  game core accepts the hit
//   overrun    one-cycle pulse after a cycle that dropped at least one press
module whack_button_conditioner #(
    parameter  int N_BUTTONS       = 8,
    parameter  int DEBOUNCE_CYCLES = 5000,
    localparam int IDX_W           = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic                 hit_valid,
    output logic [IDX_W-1:0]     hit_idx,
    input  logic                 hit_ready,
    output logic                 overrun
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0] sync_a;
    logic [N_BUTTONS-1:0] sync_b;
    logic [CNT_W-1:0]     cnt [N_BUTTONS];

    logic                 press_any;
    logic                 press_multi;
    logic [IDX_W-1:0]     press_idx;
    logic                 slot_free;

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Per-button debounce: the counter runs only while the synchronised level
    // disagrees with the accepted level; any agreement restarts it from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level <= '0;
            btn_press <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_press <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (sync_b[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]       <= '0;
                    btn_level[i] <= sync_b[i];
                    // Only a 0->1 acceptance produces a press pulse.
                    btn_press[i] <= sync_b[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority pick of the lowest pressed index; more than one bit set means
    // the others are lost even if the slot is free.
    always_comb begin
        press_idx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (btn_press[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

    assign press_any   = |btn_press;
    assign press_multi = |(btn_press & (btn_press - 1'b1));
    assign slot_free   = !hit_valid || hit_ready;

    // Single-entry hit slot. Accepting and loading in the same cycle keeps
    // hit_valid high with the new index; hit_idx is never cleared on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_idx   <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (press_any) begin
                if (slot_free) begin
                    hit_valid <= 1'b1;
                    hit_idx   <= press_idx;
                    overrun   <= press_multi;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (hit_ready) begin
                hit_valid <= 1'b0;
            end
        end
    end

endmodule
